// File: rtl/sixty_four_bit_css_pipe.sv
// sixty_four_bit_css_pipe: two-stage carry-select subtractor a - b - borrow_in with valid/ready flow control
module sixty_four_bit_css_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   localparam int HALF = WIDTH / 2;
   logic [HALF:0]      lo_sum, hi0_sum, hi1_sum;
   logic               s1_v, s1_sel, s1_c0, s1_c1, s1_am, s1_bm;
   logic [HALF-1:0]    s1_lo, s1_hi0, s1_hi1, hi_sel;
   logic               c_sel, s2_free, s1_adv, in_hs;
   logic [WIDTH-1:0]   res;
   // Subtraction as a + ~b + carry, carry_in = !borrow_in; upper half speculated both ways
   always_comb begin
      lo_sum  = {1'b0, a[HALF-1:0]} + {1'b0, ~b[HALF-1:0]} + {{HALF{1'b0}}, !borrow_in};
      hi0_sum = {1'b0, a[WIDTH-1:HALF]} + {1'b0, ~b[WIDTH-1:HALF]};
      hi1_sum = hi0_sum + {{HALF{1'b0}}, 1'b1};
      hi_sel  = s1_sel ? s1_hi1 : s1_hi0;
      c_sel   = s1_sel ? s1_c1 : s1_c0;
      res     = {hi_sel, s1_lo};
      s2_free = !out_valid || out_ready;
      s1_adv  = s1_v && s2_free;
      in_ready = !s1_v || s2_free;
      in_hs   = in_valid && in_ready;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_lo  <= '0;
         s1_sel <= 1'b0;
         s1_hi0 <= '0;
         s1_hi1 <= '0;
         s1_c0  <= 1'b0;
         s1_c1  <= 1'b0;
         s1_am  <= 1'b0;
         s1_bm  <= 1'b0;
      end else if (in_hs) begin
         s1_v   <= 1'b1;
         s1_lo  <= lo_sum[HALF-1:0];
         s1_sel <= lo_sum[HALF];
         s1_hi0 <= hi0_sum[HALF-1:0];
         s1_hi1 <= hi1_sum[HALF-1:0];
         s1_c0  <= hi0_sum[HALF];
         s1_c1  <= hi1_sum[HALF];
         s1_am  <= a[WIDTH-1];
         s1_bm  <= b[WIDTH-1];
      end else if (s1_adv) begin
         s1_v <= 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         negative   <= 1'b0;
      end else begin
         if (s2_free) out_valid <= s1_v;
         if (s1_adv) begin
            diff       <= res;
            borrow_out <= !c_sel;
            overflow   <= (s1_am != s1_bm) && (hi_sel[HALF-1] != s1_am);
            zero       <= (res == '0);
            negative   <= hi_sel[HALF-1];
         end
      end
   end
endmodule

// File: tb/tb_sixty_four_bit_css_pipe.sv
// tb_sixty_four_bit_css_pipe: directed vectors, backpressure and mid-flight reset for the subtractor pipe
module tb_sixty_four_bit_css_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        borrow_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] diff;
   logic        borrow_out, overflow, zero, negative;
   int          checks = 0;
   int          errors = 0;

   sixty_four_bit_css_pipe #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
      .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
      .overflow(overflow), .zero(zero), .negative(negative)
   );

   always #5 clk = ~clk;

   // One beat in, result checked two edges later; {out_valid,diff,borrow,ovf,zero,neg}
   task automatic run_vec(input string name, input logic [63:0] va, input logic [63:0] vb,
                          input logic vbi, input logic [63:0] ed, input logic ebo,
                          input logic eov, input logic ez, input logic en);
      logic [68:0] got, exp;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; a = va; b = vb; borrow_in = vbi;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      got = {out_valid, diff, borrow_out, overflow, zero, negative};
      exp = {1'b1, ed, ebo, eov, ez, en};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got v=%0b d=%h bo=%0b ov=%0b z=%0b n=%0b, want v=%0b d=%h bo=%0b ov=%0b z=%0b n=%0b",
                  name, got[68], got[67:4], got[3], got[2], got[1], got[0],
                  exp[68], exp[67:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({out_valid, in_ready, diff, borrow_out, overflow, zero, negative} !== {1'b0, 1'b1, 64'd0, 4'b0}) begin
         errors++;
         $display("FAIL reset_state: out_valid=%0b in_ready=%0b diff=%h flags=%b, want 0 1 0 0000",
                  out_valid, in_ready, diff, {borrow_out, overflow, zero, negative});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith();
      run_vec("basic",      64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("cross_half", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      run_vec("underflow",  64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
      run_vec("ovf_neg",    64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("zero",       64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_vec("eq_borrow",  64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      run_vec("ovf_pos",    64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
      run_vec("lo_borrow_hi", 64'h0000_0002_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int recv = 0;
      logic ir;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         in_valid = (idx < 4);
         a = 64'd100 + 64'(idx);
         b = 64'(idx);
         borrow_in = 1'b0;
         #1;
         ir = in_ready;
         if (c == 2 || c == 4) begin
            checks++;
            if (ir !== 1'b0 || idx != 2) begin
               errors++;
               $display("FAIL bp_stall c=%0d: in_ready=%0b accepted=%0d, want 0 and 2", c, ir, idx);
            end
         end
         if (c >= 2 && c <= 4) begin
            checks++;
            if (out_valid !== 1'b1 || diff !== 64'd100) begin
               errors++;
               $display("FAIL bp_hold c=%0d: out_valid=%0b diff=%0d, want 1 and 100", c, out_valid, diff);
            end
         end
         if (c >= 5 && c <= 8) begin
            checks++;
            if (out_valid !== 1'b1 || diff !== 64'd100) begin
               errors++;
               $display("FAIL bp_drain c=%0d: out_valid=%0b diff=%0d, want 1 and 100", c, out_valid, diff);
            end
         end
         if (out_valid && out_ready) recv++;
         @(posedge clk);
         if (in_valid && ir) idx++;
      end
      in_valid = 1'b0;
      checks++;
      if (recv != 4 || idx != 4) begin
         errors++;
         $display("FAIL bp_count: received=%0d accepted=%0d, want 4 and 4", recv, idx);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; a = 64'd50; b = 64'd1; borrow_in = 1'b0;
      @(negedge clk);
      a = 64'd60;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || diff !== 64'd49) begin
         errors++;
         $display("FAIL rst_pre: out_valid=%0b diff=%0d, want 1 and 49", out_valid, diff);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, diff, borrow_out, overflow, zero, negative} !== {1'b0, 1'b1, 64'd0, 4'b0}) begin
         errors++;
         $display("FAIL rst_mid: out_valid=%0b in_ready=%0b diff=%h flags=%b, want 0 1 0 0000",
                  out_valid, in_ready, diff, {borrow_out, overflow, zero, negative});
      end
      #1 rst = 1'b0;
      run_vec("post_reset", 64'd5, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_drain: out_valid=%0b, want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sixty_four_bit_css_pipe.md
Name: sixty_four_bit_css_pipe

Overview:
- Pipelined 64-bit carry-select subtractor: computes diff = a - b - borrow_in.
- It is the inverse-direction companion to the team's 64-bit carry-select adder and is intended for the ALU datapath and a future multi-cycle divider.
- Two register stages with valid/ready handshakes on both sides.
- Reports borrow, signed overflow, zero and negative flags with each result.

Parameters:
- WIDTH, 64, operand width; must be even. HALF = WIDTH/2 is the select-split point.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat presented
- in_ready  output  1  block accepts operand beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  borrow into bit 0
- out_valid  output  1  result beat presented
- out_ready  input  1  consumer accepts result beat
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
- borrow_out  output  1  1 when unsigned a < b + borrow_in
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0
- negative  output  1  diff[WIDTH-1]

Behaviour:
- Arithmetic: diff = a + ~b + ~borrow_in, where carry_in = !borrow_in and borrow_out = !carry_out. overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- Stage 1 (S1), registered on an input handshake (in_valid && in_ready):
  - Low-half ripple difference a[HALF-1:0] - b[HALF-1:0] with carry_in = !borrow_in. Register the low diff and the low carry (sel).
  - Two upper-half candidates, one assuming carry 0 and one assuming carry 1. Register both candidate sums and both carry-outs.
  - Register a[MSB] and b[MSB].
- Stage 2 (S2), registered when S1 advances:
  - sel chooses the upper-half candidate and its carry.
  - Register diff, borrow_out, overflow, zero and negative.
  - Flags are computed from the selected result in the same cycle, so they are aligned with diff.
- Valid bits:
  - s1_v is set on an input handshake and cleared when S1 advances without a new input.
  - s2_v equals out_valid.
- Advance rules:
  - s2_free = !s2_v || out_ready
  - S1 advances into S2 when s1_v && s2_free.
  - in_ready = !s1_v || s2_free. This is combinational from out_ready; there is no skid buffer.
- Latency: 2 cycles from input handshake to out_valid with no stalls. Throughput is 1 beat/cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, S2 holds diff and all flags stable.
  - If S1 is also full, in_ready = 0 and S1 holds.
  - No beat is dropped or duplicated.
- Simultaneous events: an output handshake, an S1->S2 advance and a new input handshake can all occur in the same cycle. Each stage takes its upstream data on that edge.
- Empty pipeline: in_ready = 1 and out_valid = 0.
- Reset:
  - Asserting rst at any time immediately clears s1_v, s2_v, out_valid, diff, borrow_out, overflow, zero and negative to 0.
  - Any in-flight beats are discarded.
  - in_ready reads 1 while in reset.
  - After deassertion, the first input handshake can occur on the first rising edge.
- Inputs are sampled only on a handshake. a, b and borrow_in are don't-care when in_valid = 0.

Test Plan:
- Basic, no borrow, out_ready = 1: a=64'd10, b=64'd3, borrow_in=0 -> 2 cycles later out_valid=1, diff=7, borrow_out=0, overflow=0, zero=0, negative=0.
- Cross-half borrow propagation: a=64'h0000_0001_0000_0000, b=1, borrow_in=0 -> diff=64'h0000_0000_FFFF_FFFF, borrow_out=0. Exercises the sel=0 candidate path.
- Underflow: a=0, b=1, borrow_in=1 -> diff=64'hFFFF_FFFF_FFFF_FFFE, borrow_out=1, negative=1, overflow=0.
- Signed overflow and zero:
  - a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, borrow_out=0.
  - a=b=64'h1234_5678_9ABC_DEF0, borrow_in=0 -> diff=0, zero=1.
- Backpressure:
  - Stream 4 beats (a=100+i, b=i) with out_ready held 0 -> in_ready drops after 2 accepted beats, and diff holds 100 stable.
  - Then raise out_ready -> results 100,100,100,100 emerge in order, one per cycle, with no loss or duplication.
- Reset mid-operation:
  - With 2 beats in flight, pulse rst between clock edges -> out_valid and all outputs go to 0 immediately and in_ready=1.
  - A post-reset beat a=5, b=2 then returns diff=3 after 2 cycles.
